udp2mstq: RTL and testbench



---
 rtl/udp2mstq.sv | 195 +++++++++++++++++++
 tb/tb_udp2mstq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp2mstq.sv
// rtl/udp2mstq.sv - UDP receive parser feeding tagged address/data words to the PCIe master write queue
// Preamble strip, Ethernet/IPv4/UDP header checks, then 48-bit address and payload words via a 2-entry skid.
module udp2mstq #(
   parameter logic [15:0] UDP_PORT = 16'd3422,
   parameter int          MAX_DATA = 128
) (
   input  logic        pcie_clk,
   input  logic        sys_rst,
   input  logic [8:0]  phy_dout,
   input  logic        phy_empty,
   output logic        phy_rd_en,
   output logic [17:0] mst_din,
   input  logic        mst_full,
   output logic        mst_wr_en,
   input  logic [31:0] if_v4addr,
   input  logic [47:0] if_macaddr,
   output logic [15:0] rx_frames,
   output logic [15:0] rx_drops
);

   typedef enum logic [2:0] {IDLE, PRE, HDR, ADDR, DATA, SKIP} state_t;

   state_t      state;
   logic [5:0]  off;
   logic [7:0]  hi;
   logic [7:0]  len_hi;
   logic [15:0] words_left;
   logic        phase, m_loc, m_bc, pend, rd_d;
   logic [17:0] s0, s1;
   logic [1:0]  cnt;

   logic        in_frame, hdr_fail, push, last_word, mac_loc_n, mac_bc_n, len_bad;
   logic [7:0]  b, mac_byte;
   logic [15:0] udp_len, data_len;
   logic [17:0] push_word;

   assign in_frame  = phy_dout[8];
   assign b         = phy_dout[7:0];
   assign udp_len   = {len_hi, b};
   assign data_len  = udp_len - 16'd14;
   assign len_bad   = (udp_len < 16'd16) || data_len[0] || (data_len > 16'(MAX_DATA));
   assign last_word = (words_left == 16'd1);
   assign mac_loc_n = m_loc && (b == mac_byte);
   assign mac_bc_n  = m_bc && (b == 8'hFF);

   // Reading stalls whenever the skid holds anything; the in-flight byte lands in the spare entry.
   assign phy_rd_en = !sys_rst && !phy_empty && (cnt == 2'd0);
   assign mst_wr_en = !sys_rst && (cnt != 2'd0) && !mst_full;
   assign mst_din   = s0;

   always_comb begin
      mac_byte = if_macaddr[7:0];
      case (off[2:0])
         3'd0: mac_byte = if_macaddr[47:40];
         3'd1: mac_byte = if_macaddr[39:32];
         3'd2: mac_byte = if_macaddr[31:24];
         3'd3: mac_byte = if_macaddr[23:16];
         3'd4: mac_byte = if_macaddr[15:8];
         default: mac_byte = if_macaddr[7:0];
      endcase
   end

   always_comb begin
      hdr_fail = 1'b0;
      case (off)
         6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: hdr_fail = !(mac_loc_n || mac_bc_n);
         6'd12: hdr_fail = (b != 8'h08);
         6'd13: hdr_fail = (b != 8'h00);
         6'd14: hdr_fail = (b != 8'h45);
         6'd23: hdr_fail = (b != 8'h11);
         6'd30: hdr_fail = (b != if_v4addr[31:24]);
         6'd31: hdr_fail = (b != if_v4addr[23:16]);
         6'd32: hdr_fail = (b != if_v4addr[15:8]);
         6'd33: hdr_fail = (b != if_v4addr[7:0]);
         6'd36: hdr_fail = (b != UDP_PORT[15:8]);
         6'd37: hdr_fail = (b != UDP_PORT[7:0]);
         6'd39: hdr_fail = len_bad;
         default: hdr_fail = 1'b0;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      push_word = '0;
      if (rd_d) begin
         if (!in_frame) begin
            if (state == ADDR || state == DATA) begin
               push      = 1'b1;
               push_word = {2'b11, 16'h0000};
            end
         end else if (state == ADDR && off[0]) begin
            push      = 1'b1;
            push_word = {2'b10, hi, b};
         end else if (state == DATA && phase) begin
            push      = 1'b1;
            push_word = {(last_word ? 2'b01 : 2'b00), hi, b};
         end
      end
   end

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge pcie_clk) begin
      if (sys_rst) begin
         state <= IDLE; off <= '0; hi <= '0; len_hi <= '0; words_left <= '0;
         phase <= 1'b0; m_loc <= 1'b0; m_bc <= 1'b0; pend <= 1'b0; rd_d <= 1'b0;
         s0 <= '0; s1 <= '0; cnt <= '0;
         rx_frames <= '0; rx_drops <= '0;
      end else begin
         rd_d <= phy_rd_en;
         case ({push, mst_wr_en})
            2'b10: begin
               if (cnt == 2'd0) s0 <= push_word;
               else             s1 <= push_word;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               s0  <= s1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) s0 <= push_word;
               else begin
                  s0 <= s1;
                  s1 <= push_word;
               end
            end
            default: ;
         endcase

         if (rd_d && !in_frame) begin
            // SFD failures are counted here, at the end of the frame, via pend.
            if (state == PRE || state == HDR || state == ADDR || state == DATA || (state == SKIP && pend))
               rx_drops <= sat_inc(rx_drops);
            state <= IDLE;
            pend  <= 1'b0;
         end else if (rd_d) begin
            case (state)
               IDLE, PRE: begin
                  if (b == 8'h55) state <= PRE;
                  else if (b == 8'hD5) begin
                     state <= HDR;
                     off   <= '0;
                     m_loc <= 1'b1;
                     m_bc  <= 1'b1;
                  end else begin
                     state <= SKIP;
                     pend  <= 1'b1;
                  end
               end
               HDR: begin
                  if (hdr_fail) begin
                     state    <= SKIP;
                     pend     <= 1'b0;
                     rx_drops <= sat_inc(rx_drops);
                  end else begin
                     off <= off + 6'd1;
                     if (off <= 6'd5) begin
                        m_loc <= mac_loc_n;
                        m_bc  <= mac_bc_n;
                     end
                     if (off == 6'd38) len_hi <= b;
                     if (off == 6'd39) words_left <= {1'b0, data_len[15:1]};
                     if (off == 6'd41) state <= ADDR;
                  end
               end
               ADDR: begin
                  off <= off + 6'd1;
                  if (!off[0]) hi <= b;
                  if (off == 6'd47) begin
                     state <= DATA;
                     phase <= 1'b0;
                  end
               end
               DATA: begin
                  phase <= !phase;
                  if (!phase) hi <= b;
                  else begin
                     words_left <= words_left - 16'd1;
                     if (last_word) begin
                        rx_frames <= sat_inc(rx_frames);
                        state     <= SKIP;
                        pend      <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_udp2mstq.sv
// tb/tb_udp2mstq.sv - directed bench for udp2mstq with a FIFO model and a master-queue monitor
module tb_udp2mstq;

   logic        pcie_clk, sys_rst, phy_empty, phy_rd_en, mst_full, mst_wr_en;
   logic [8:0]  phy_dout;
   logic [17:0] mst_din;
   logic [31:0] if_v4addr;
   logic [47:0] if_macaddr;
   logic [15:0] rx_frames, rx_drops;

   udp2mstq dut (
      .pcie_clk(pcie_clk), .sys_rst(sys_rst),
      .phy_dout(phy_dout), .phy_empty(phy_empty), .phy_rd_en(phy_rd_en),
      .mst_din(mst_din), .mst_full(mst_full), .mst_wr_en(mst_wr_en),
      .if_v4addr(if_v4addr), .if_macaddr(if_macaddr),
      .rx_frames(rx_frames), .rx_drops(rx_drops)
   );

   localparam logic [47:0] MY_MAC = 48'h003776000001;
   localparam logic [31:0] MY_IP  = 32'h0A0015C7;

   logic [8:0]  mem [0:4095];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic [17:0] got [0:1023];
   int          got_n = 0;
   int          bad_hs = 0;
   int          base = 0;
   int          checks = 0;
   int          errors = 0;
   bit          rand_en = 0;
   logic [17:0] exp_q [$];

   initial begin
      pcie_clk = 0;
      forever #5 pcie_clk = ~pcie_clk;
   end

   assign phy_empty = (rd_ptr == wr_ptr);

   always @(posedge pcie_clk) begin
      if (phy_rd_en) begin
         phy_dout <= mem[rd_ptr[11:0]];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   always @(posedge pcie_clk) begin
      if (mst_wr_en) begin
         got[got_n[9:0]] <= mst_din;
         got_n <= got_n + 1;
      end
      if ((mst_wr_en && mst_full) || (mst_wr_en && phy_rd_en)) bad_hs <= bad_hs + 1;
   end

   initial begin
      mst_full = 1'b0;
      forever begin
         @(negedge pcie_clk);
         mst_full = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [8:0] e);
      mem[wr_ptr[11:0]] = e;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic send_frame(input logic [47:0] mac, input logic [31:0] ip, input logic [7:0] proto,
                             input logic [15:0] port, input logic [15:0] ulen, input logic [47:0] addr,
                             input int ndata, input bit fcs);
      logic [7:0] h [48];
      for (int i = 0; i < 48; i++) h[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         h[i]      = mac[47-8*i -: 8];
         h[42 + i] = addr[47-8*i -: 8];
      end
      h[6] = 8'h02; h[11] = 8'h09; h[12] = 8'h08; h[14] = 8'h45; h[22] = 8'h40; h[23] = proto;
      h[26] = 8'h0A; h[28] = 8'h15; h[29] = 8'h01; h[34] = 8'hC0;
      for (int i = 0; i < 4; i++) h[30 + i] = ip[31-8*i -: 8];
      h[36] = port[15:8]; h[37] = port[7:0]; h[38] = ulen[15:8]; h[39] = ulen[7:0];
      for (int i = 0; i < 7; i++) put({1'b1, 8'h55});
      put({1'b1, 8'hD5});
      for (int i = 0; i < 48; i++) put({1'b1, h[i]});
      for (int i = 0; i < ndata; i++) put({1'b1, 8'(i + 1)});
      if (fcs) for (int i = 0; i < 4; i++) put({1'b1, 8'hA5});
      put({1'b0, 8'h00});
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (rd_ptr != wr_ptr && n < 5000) begin
         @(posedge pcie_clk);
         n++;
      end
      repeat (60) @(posedge pcie_clk);
      @(negedge pcie_clk);
      chk({tag, "_drain"}, 32'(rd_ptr == wr_ptr), 32'd1);
   endtask

   task automatic check_words(input string tag);
      chk({tag, "_count"}, 32'(got_n - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_n - base; i++)
         chk($sformatf("%s_w%0d", tag, i), 32'(got[(base + i) % 1024]), 32'(exp_q[i]));
      base = got_n;
      exp_q.delete();
   endtask

   task automatic exp_t1();
      exp_q = '{18'h20000, 18'h2D000, 18'h21000, 18'h00102, 18'h00304, 18'h00506, 18'h10708};
   endtask

   initial begin
      sys_rst    = 1'b1;
      if_macaddr = MY_MAC;
      if_v4addr  = MY_IP;
      repeat (3) @(posedge pcie_clk);
      #1;
      chk("rst_rd_en", 32'(phy_rd_en), 32'd0);
      chk("rst_wr_en", 32'(mst_wr_en), 32'd0);
      chk("rst_din", 32'(mst_din), 32'd0);
      chk("rst_frames", 32'(rx_frames), 32'd0);
      chk("rst_drops", 32'(rx_drops), 32'd0);
      @(negedge pcie_clk);
      sys_rst = 1'b0;

      // Basic valid frame
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3422, 16'd22, 48'h0000D0001000, 8, 1);
      drain("t1");
      exp_t1();
      check_words("t1");
      chk("t1_frames", 32'(rx_frames), 32'd1);
      chk("t1_drops", 32'(rx_drops), 32'd0);

      // Same frame under random backpressure
      rand_en = 1;
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3422, 16'd22, 48'h0000D0001000, 8, 1);
      drain("bp");
      rand_en = 0;
      repeat (4) @(negedge pcie_clk);
      exp_t1();
      check_words("bp");
      chk("bp_frames", 32'(rx_frames), 32'd2);
      chk("bp_handshake", 32'(bad_hs), 32'd0);

      // Broadcast, maximum payload
      send_frame(48'hFFFFFFFFFFFF, MY_IP, 8'h11, 16'd3422, 16'd142, 48'h123456789ABC, 128, 1);
      drain("max");
      exp_q = '{18'h21234, 18'h25678, 18'h29ABC};
      for (int i = 0; i < 64; i++)
         exp_q.push_back({(i == 63) ? 2'b01 : 2'b00, 8'(2*i + 1), 8'(2*i + 2)});
      check_words("max");
      chk("max_frames", 32'(rx_frames), 32'd3);

      // Oversize payload
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3422, 16'd144, 48'h0, 130, 1);
      drain("big");
      check_words("big");
      chk("big_drops", 32'(rx_drops), 32'd1);

      // Header rejections
      send_frame(MY_MAC, MY_IP, 8'h06, 16'd3422, 16'd22, 48'h0, 8, 1);
      drain("proto");
      chk("proto_drops", 32'(rx_drops), 32'd2);
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3423, 16'd22, 48'h0, 8, 1);
      drain("port");
      chk("port_drops", 32'(rx_drops), 32'd3);
      send_frame(MY_MAC, 32'h0A0015C8, 8'h11, 16'd3422, 16'd22, 48'h0, 8, 1);
      drain("ip");
      chk("ip_drops", 32'(rx_drops), 32'd4);
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3422, 16'd21, 48'h0, 8, 1);
      drain("odd");
      chk("odd_drops", 32'(rx_drops), 32'd5);
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3422, 16'd8, 48'h0, 8, 1);
      drain("short");
      chk("short_drops", 32'(rx_drops), 32'd6);
      send_frame(48'h003776000002, MY_IP, 8'h11, 16'd3422, 16'd22, 48'h0, 8, 1);
      drain("mac");
      chk("mac_drops", 32'(rx_drops), 32'd7);
      check_words("rej");
      chk("rej_frames", 32'(rx_frames), 32'd3);

      // Truncated after 3 data bytes
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3422, 16'd22, 48'h0000D0001000, 3, 0);
      drain("cut");
      exp_q = '{18'h20000, 18'h2D000, 18'h21000, 18'h00102, 18'h30000};
      check_words("cut");
      chk("cut_drops", 32'(rx_drops), 32'd8);
      chk("cut_frames", 32'(rx_frames), 32'd3);

      // Reset in the middle of DATA
      send_frame(48'hFFFFFFFFFFFF, MY_IP, 8'h11, 16'd3422, 16'd142, 48'h123456789ABC, 128, 1);
      begin
         int n = 0;
         while (got_n < base + 5 && n < 2000) begin
            @(posedge pcie_clk);
            n++;
         end
      end
      @(negedge pcie_clk);
      chk("mid_reached", 32'(got_n >= base + 5), 32'd1);
      sys_rst = 1'b1;
      @(posedge pcie_clk);
      #1;
      chk("mid_rd_en", 32'(phy_rd_en), 32'd0);
      chk("mid_wr_en", 32'(mst_wr_en), 32'd0);
      chk("mid_din", 32'(mst_din), 32'd0);
      chk("mid_frames", 32'(rx_frames), 32'd0);
      chk("mid_drops", 32'(rx_drops), 32'd0);
      @(negedge pcie_clk);
      sys_rst = 1'b0;
      base = got_n;
      drain("rem");
      check_words("rem");
      chk("rem_drops", 32'(rx_drops), 32'd1);
      chk("rem_frames", 32'(rx_frames), 32'd0);
      send_frame(MY_MAC, MY_IP, 8'h11, 16'd3422, 16'd22, 48'h0000D0001000, 8, 1);
      drain("post");
      exp_t1();
      check_words("post");
      chk("post_frames", 32'(rx_frames), 32'd1);
      chk("post_drops", 32'(rx_drops), 32'd1);
      chk("final_handshake", 32'(bad_hs), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
